incr_serial_seq: RTL and testbench

- Bit-serial sequencer that increments a WIDTH-bit operand by one, using a single shared half-adder cell over multiple cycles.
- Replaces the flat ripple incrementer where area matters more than latency.
- Operand enters through a valid/ready input handshake; result leaves through a valid/ready output handshake.
- Sits between an operand producer (e.g. a program/address register) and its consumer.

---
 rtl/incr_serial_seq_pkg.sv | 12 +
 rtl/incr_serial_seq_if.sv | 27 ++
 rtl/incr_serial_seq_half_adder.sv | 12 +
 rtl/incr_serial_seq.sv | 105 ++++++++++
 tb/tb_incr_serial_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/incr_serial_seq_pkg.sv
// Shared types for the bit-serial incrementer: FSM state encoding and default width.
package incr_seq_pkg;

  localparam int INCR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/incr_serial_seq_if.sv
// Operand/result handshake bundle for incr_serial_seq; slave is the sequencer side.
interface incr_serial_seq_if
  import incr_seq_pkg::*;
#(
  parameter int WIDTH = INCR_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, s, cout, busy
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, s, cout, busy
  );

endinterface

// File: rtl/incr_serial_seq_half_adder.sv
// Single half-adder cell shared across all bit positions of the serial incrementer.
module half_adder_cell (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y;
  assign carry = x & y;

endmodule

// File: rtl/incr_serial_seq.sv
// Bit-serial +1 sequencer: one half-adder cell walks the operand LSB-first.
// Optional macro INCR_SERIAL_EARLY_EXIT_EN finishes as soon as the carry dies.
module incr_serial_seq
  import incr_seq_pkg::*;
#(
  parameter int WIDTH = INCR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  incr_serial_seq_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  logic bit_sel;
  logic ha_sum;
  logic ha_carry;
  logic finish;

  assign bit_sel = work_q[idx_q];

  half_adder_cell u_ha (
    .x     (bit_sel),
    .y     (carry_q),
    .sum   (ha_sum),
    .carry (ha_carry)
  );

`ifdef INCR_SERIAL_EARLY_EXIT_EN
  // Once the carry is zero the untouched upper bits already hold the result.
  assign finish = (idx_q == LAST_IDX) || !ha_carry;
`else
  assign finish = (idx_q == LAST_IDX);
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.a;
          carry_d = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[idx_q] = ha_sum;
        carry_d       = ha_carry;
        if (finish) begin
          // Result is captured separately so s stays frozen outside DONE.
          s_d     = work_d;
          cout_d  = ha_carry;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      carry_q <= 1'b1;
      idx_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_incr_serial_seq.sv
// Scoreboard bench for incr_serial_seq: driver pushes model results, monitor pops on out_valid.
module tb_incr_serial_seq;
  import incr_seq_pkg::*;

  localparam int W = INCR_W;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    int           lat;
    int           acceptCycle;
    int           stall;
    bit           btb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   lastHsCycle = -100;
  bit   prevHeld = 1'b0;
  exp_t sbQ[$];

  incr_serial_seq_if #(.WIDTH(W)) bus ();

  incr_serial_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Reference: plain arithmetic for the sum; latency counts the accept edge as the first edge.
  function automatic exp_t refModel(input logic [W-1:0] op);
    exp_t       e;
    logic [W:0] sum;
    int         k;
    sum    = {1'b0, op} + {{W{1'b0}}, 1'b1};
    e.s    = sum[W-1:0];
    e.cout = sum[W];
    k = W;
    for (int i = W - 1; i >= 0; i--) if (!op[i]) k = i;
`ifdef INCR_SERIAL_EARLY_EXIT_EN
    e.lat = (k < W) ? k + 2 : W + 1;
`else
    e.lat = W + 1;
`endif
    e.acceptCycle = 0;
    e.stall = 0;
    e.btb = 1'b0;
    return e;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] op, input int stall, input bit holdValid);
    exp_t e;
    bit   accepted;
    logic rdy;
    accepted = 1'b0;
    bus.a = op;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 400 && !accepted; t++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) accepted = 1'b1;
    end
    checkOutput("accept", {63'd0, accepted}, 64'd1);
    e = refModel(op);
    e.acceptCycle = cycle;
    e.stall = stall;
    e.btb = prevHeld;
    if (accepted) sbQ.push_back(e);
    bus.a = '1;
    bus.in_valid = holdValid;
    prevHeld = holdValid;
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 600 && sbQ.size() != 0; t++) @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("drain", 64'(sbQ.size()), 64'd0);
  endtask

  // Monitor: compares on the first cycle out_valid is seen, then optionally stalls the consumer.
  initial begin
    exp_t e;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.out_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_result", 64'd1, 64'd0);
          e.s = bus.s;
          e.stall = 0;
        end else begin
          e = sbQ.pop_front();
          checkOutput("s", 64'(bus.s), 64'(e.s));
          checkOutput("cout", {63'd0, bus.cout}, {63'd0, e.cout});
          checkOutput("latency", 64'(cycle - e.acceptCycle + 1), 64'(e.lat));
          checkOutput("in_ready_done", {63'd0, bus.in_ready}, 64'd0);
          if (e.btb) checkOutput("idle_bubble", 64'(e.acceptCycle - lastHsCycle), 64'd1);
        end
        for (int i = 0; i < e.stall; i++) begin
          @(posedge clk);
          #1;
          checkOutput("stall_s", 64'(bus.s), 64'(e.s));
          checkOutput("stall_valid", {63'd0, bus.out_valid}, 64'd1);
          checkOutput("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("handshake", {63'd0, bus.out_valid}, 64'd0);
        lastHsCycle = cycle;
        bus.out_ready = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] op;
    logic [W-1:0] ones;
    int           k;
    int           kind;
    bit           hold;

    bus.in_valid = 1'b0;
    bus.a = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("reset_s", 64'(bus.s), 64'd0);
    checkOutput("reset_cout", {63'd0, bus.cout}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(16'h0000, 0, 1'b0);
    applyStimulus(16'hFFFF, 0, 1'b0);
    applyStimulus(16'h00FF, 5, 1'b0);
    applyStimulus(16'h1234, 0, 1'b1);
    applyStimulus(16'h7FFF, 0, 1'b0);
    applyStimulus(16'h0003, 0, 1'b0);
    waitDrain();

    // Abort an operation at bit index 7; the pending expectation is withdrawn.
    applyStimulus(16'h00FF, 0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("run_busy", {63'd0, bus.busy}, 64'd1);
    checkOutput("run_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rst_n = 1'b0;
    void'(sbQ.pop_back());
    #1;
    checkOutput("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("abort_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    prevHeld = 1'b0;
    applyStimulus(16'h0001, 0, 1'b0);
    waitDrain();

    ones = '1;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 3);
      k = $urandom_range(0, W - 1);
      case (kind)
        0: op = W'($urandom);
        1: op = W'($urandom) | ~(ones << k);
        2: op = '1;
        default: op = ~(ones << k);
      endcase
      hold = (n == 23) ? 1'b0 : 1'($urandom_range(0, 1));
      applyStimulus(op, $urandom_range(0, 3), hold);
    end
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
